// File: rtl/recording_player.sv
// rtl/recording_player.sv - playback engine that sounds each recorded note entry as a square-wave tone
module recording_player #(
    parameter int NOTE_TICKS = 25000000,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W:0]   length,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [5:0]        rd_data,
    output logic              busy,
    output logic              done,
    output logic              note_valid,
    output logic [2:0]        cur_octave,
    output logic [2:0]        cur_note,
    output logic              audio_out
);

    localparam int                TICK_W    = $clog2(NOTE_TICKS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(NOTE_TICKS - 1);
    localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, PLAY} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W:0]   len_q;
    logic [TICK_W-1:0] tick;
    logic [23:0]       half_cnt;
    logic [23:0]       half_period;
    logic              tone;
    logic              done_q;
    logic [2:0]        oct_q;
    logic [2:0]        note_q;
    logic              last_tick;
    logic              last_entry;
    logic              abort;
    logic              is_rest;

    // Octave-4 half period for the note, scaled by powers of two for other octaves; 0 marks a rest
    function automatic logic [23:0] half_period_of(input logic [5:0] entry);
        logic [23:0] base;
        logic [2:0]  oct;
        oct = entry[5:3];
        case (entry[2:0])
            3'd1:    base = 24'd191113;
            3'd2:    base = 24'd170262;
            3'd3:    base = 24'd151686;
            3'd4:    base = 24'd143173;
            3'd5:    base = 24'd127551;
            3'd6:    base = 24'd113636;
            3'd7:    base = 24'd101239;
            default: base = 24'd0;
        endcase
        if (oct == 3'd0)
            half_period_of = 24'd0;
        else if (oct >= 3'd4)
            half_period_of = base >> (oct - 3'd4);
        else
            half_period_of = base << (3'd4 - oct);
    endfunction

    assign last_tick  = (tick == TICK_LAST);
    // idx is one bit narrower than length so a full 2**ADDR_W recording ends without wrapping
    assign last_entry = ({1'b0, idx} == (len_q - LEN_ONE));
    assign abort      = stop && (state != IDLE);
    assign is_rest    = (oct_q == 3'd0) || (note_q == 3'd0);

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; stop overrides everything once playback is under way
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && (length != '0)) state_nxt = FETCH;
            FETCH:   state_nxt = WAIT;
            WAIT:    state_nxt = PLAY;
            PLAY:    if (last_tick) state_nxt = last_entry ? IDLE : FETCH;
            default: state_nxt = IDLE;
        endcase
        if (abort)
            state_nxt = IDLE;
    end

    // Datapath: entry index, note latch, duration and half-period counters, done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            len_q       <= '0;
            tick        <= '0;
            half_cnt    <= 24'd0;
            half_period <= 24'd0;
            tone        <= 1'b0;
            done_q      <= 1'b0;
            oct_q       <= 3'd0;
            note_q      <= 3'd0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                oct_q  <= 3'd0;
                note_q <= 3'd0;
                tone   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (length == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                len_q <= length;
                                idx   <= '0;
                            end
                        end
                    end
                    WAIT: begin
                        oct_q       <= rd_data[5:3];
                        note_q      <= rd_data[2:0];
                        half_period <= half_period_of(rd_data);
                        tick        <= '0;
                        half_cnt    <= 24'd0;
                        tone        <= 1'b0;
                    end
                    PLAY: begin
                        tick <= tick + TICK_W'(1);
                        // A rest leaves the tone low for the whole duration
                        if (!is_rest) begin
                            if (half_cnt == (half_period - 24'd1)) begin
                                half_cnt <= 24'd0;
                                tone     <= ~tone;
                            end else begin
                                half_cnt <= half_cnt + 24'd1;
                            end
                        end
                        if (last_tick) begin
                            if (last_entry)
                                done_q <= 1'b1;
                            else
                                idx <= idx + ADDR_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Outputs decoded from state; rd_addr follows idx, which only moves when entering FETCH
    always_comb begin
        rd_en      = (state == FETCH);
        busy       = (state != IDLE);
        note_valid = (state == PLAY);
        audio_out  = (state == PLAY) && tone;
        rd_addr    = idx;
        done       = done_q;
        cur_octave = oct_q;
        cur_note   = note_q;
    end

endmodule

// File: tb/tb_recording_player.sv
// tb/tb_recording_player.sv - self-checking bench for recording_player
module tb_recording_player;

    localparam int NA  = 8;
    localparam int NB  = 25000;
    localparam int INF = 32'h7fffffff;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       a_rst = 1'b1, a_start = 1'b0, a_stop = 1'b0;
    logic [8:0] a_len = 9'd0;
    logic       a_rd_en, a_busy, a_done, a_nv, a_audio;
    logic [7:0] a_rd_addr;
    logic [5:0] a_rd_data;
    logic [2:0] a_oct, a_note;

    logic       b_rst = 1'b1, b_start = 1'b0, b_stop = 1'b0;
    logic [8:0] b_len = 9'd0;
    logic       b_rd_en, b_busy, b_done, b_nv, b_audio;
    logic [7:0] b_rd_addr;
    logic [5:0] b_rd_data;
    logic [2:0] b_oct, b_note;

    logic [5:0] mem [256];

    recording_player #(.NOTE_TICKS(NA), .ADDR_W(8)) dut_a (
        .clk(clk), .rst(a_rst), .start(a_start), .stop(a_stop), .length(a_len),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .busy(a_busy), .done(a_done), .note_valid(a_nv),
        .cur_octave(a_oct), .cur_note(a_note), .audio_out(a_audio)
    );

    recording_player #(.NOTE_TICKS(NB), .ADDR_W(8)) dut_b (
        .clk(clk), .rst(b_rst), .start(b_start), .stop(b_stop), .length(b_len),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .busy(b_busy), .done(b_done), .note_valid(b_nv),
        .cur_octave(b_oct), .cur_note(b_note), .audio_out(b_audio)
    );

    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= mem[a_rd_addr];
        if (b_rd_en) b_rd_data <= mem[b_rd_addr];
    end

    // Run descriptors, written only by the stimulus: edge of first FETCH, length, stop edge, reset edge
    int r_s    [2] = '{INF, INF};
    int r_len  [2] = '{0, 0};
    int r_stop [2] = '{INF, INF};
    int r_rst  [2] = '{INF, INF};

    // Literal request mailbox and window id, written only by the stimulus
    int lit_sel = 0, lit_arg = 0, lit_want = 0, lit_at = INF;
    int win_id = 0;

    // Compare-process state
    int n_checks = 0, n_pass = 0;
    logic [7:0] hold_addr [2] = '{8'd0, 8'd0};
    logic [5:0] hold_cur  [2] = '{6'd0, 6'd0};
    int seen_win = 0;
    int w_rden = 0, w_done = 0, w_busy = 0, w_nv = 0, w_aud = 0, w_gapbad = 0;
    int w_prev_rd = -1, w_first_addr = -1;
    int got;

    function automatic int half_period(input logic [5:0] e);
        int b;
        int o;
        o = int'(e[5:3]);
        case (e[2:0])
            3'd1: b = 191113;
            3'd2: b = 170262;
            3'd3: b = 151686;
            3'd4: b = 143173;
            3'd5: b = 127551;
            3'd6: b = 113636;
            3'd7: b = 101239;
            default: b = 0;
        endcase
        if (o == 0 || b == 0) return 0;
        if (o > 4) return b / (1 << (o - 4));
        return b * (1 << (4 - o));
    endfunction

    function automatic string lit_name(input int sel);
        case (sel)
            1: return "rd_en_count";
            2: return "done_count";
            3: return "busy_cycles";
            4: return "note_valid_cycles";
            5: return "audio_high_cycles";
            6: return "rd_gap_errors";
            7: return "first_rd_addr";
            8: return "cur_entry";
            9: return "b_audio";
            10: return "half_period_table";
            11: return "a_outputs_zero";
            default: return "unknown";
        endcase
    endfunction

    // Expected outputs come from the run timeline: entry k occupies cycles s+k*(N+2) .. s+k*(N+2)+N+1
    task automatic model_check(input int id, input logic [18:0] act);
        int rel, per, k, ph, hp;
        logic b_e, d_e, r_e, n_e, au_e;
        logic [7:0] ad_e;
        logic [5:0] cu_e;
        logic [18:0] ev;
        b_e = 1'b0; d_e = 1'b0; r_e = 1'b0; n_e = 1'b0; au_e = 1'b0;
        ad_e = hold_addr[id];
        cu_e = hold_cur[id];
        per = ((id == 0) ? NA : NB) + 2;
        if (cyc == r_rst[id]) begin
            ad_e = 8'd0;
            cu_e = 6'd0;
        end else if (cyc >= r_s[id] && !(r_rst[id] > r_s[id] && cyc >= r_rst[id])) begin
            rel = cyc - r_s[id];
            if (r_stop[id] > r_s[id] && cyc >= r_stop[id]) begin
                if (cyc == r_stop[id]) cu_e = 6'd0;
            end else if (rel < r_len[id] * per) begin
                k  = rel / per;
                ph = rel % per;
                b_e  = 1'b1;
                r_e  = (ph == 0);
                ad_e = 8'(k);
                if (ph >= 2) begin
                    n_e  = 1'b1;
                    cu_e = mem[k];
                    hp   = half_period(mem[k]);
                    if (hp != 0) au_e = (((ph - 2) / hp) % 2) == 1;
                end
            end else begin
                d_e = (rel == r_len[id] * per);
            end
        end
        hold_addr[id] = ad_e;
        hold_cur[id]  = cu_e;
        ev = {b_e, d_e, r_e, ad_e, n_e, cu_e, au_e};
        n_checks++;
        if (act === ev) n_pass++;
        else $display("FAIL outputs dut%0d cyc=%0d got=%h want=%h (busy,done,rd_en,addr,nv,oct,note,audio)",
                      id, cyc, act, ev);
    endtask

    // Compare process: model check of both DUTs every cycle, event counters, literal checks
    always @(negedge clk) begin
        if (cyc >= 1) begin
            model_check(0, {a_busy, a_done, a_rd_en, a_rd_addr, a_nv, a_oct, a_note, a_audio});
            model_check(1, {b_busy, b_done, b_rd_en, b_rd_addr, b_nv, b_oct, b_note, b_audio});
        end
        if (win_id != seen_win) begin
            seen_win = win_id;
            w_rden = 0; w_done = 0; w_busy = 0; w_nv = 0; w_aud = 0; w_gapbad = 0;
            w_prev_rd = -1; w_first_addr = -1;
        end
        if (a_rd_en === 1'b1) begin
            if (w_first_addr < 0) w_first_addr = int'(a_rd_addr);
            if (w_prev_rd >= 0 && (cyc - w_prev_rd) != NA + 2) w_gapbad++;
            w_prev_rd = cyc;
            w_rden++;
        end
        if (a_done === 1'b1) w_done++;
        if (a_busy === 1'b1) w_busy++;
        if (a_nv === 1'b1) w_nv++;
        if (a_audio === 1'b1) w_aud++;
        if (cyc == lit_at) begin
            case (lit_sel)
                1: got = w_rden;
                2: got = w_done;
                3: got = w_busy;
                4: got = w_nv;
                5: got = w_aud;
                6: got = w_gapbad;
                7: got = w_first_addr;
                8: got = int'({a_oct, a_note});
                9: got = int'(b_audio);
                10: got = half_period(6'(lit_arg));
                11: got = int'({a_busy, a_done, a_rd_en, a_rd_addr, a_nv, a_oct, a_note, a_audio});
                default: got = -1;
            endcase
            n_checks++;
            if (got == lit_want) n_pass++;
            else $display("FAIL %s cyc=%0d got=%0d want=%0d", lit_name(lit_sel), cyc, got, lit_want);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic goto(input int t);
        while (cyc < t) step();
    endtask

    task automatic do_start(input int id, input int len, input bit accept);
        if (id == 0) begin a_len = 9'(len); a_start = 1'b1; end
        else begin b_len = 9'(len); b_start = 1'b1; end
        if (accept) begin
            r_s[id]   = cyc + 1;
            r_len[id] = len;
        end
        step();
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    task automatic do_stop(input int id);
        if (id == 0) a_stop = 1'b1; else b_stop = 1'b1;
        r_stop[id] = cyc + 1;
        step();
        a_stop = 1'b0;
        b_stop = 1'b0;
    endtask

    task automatic do_rst(input int id);
        if (id == 0) a_rst = 1'b1; else b_rst = 1'b1;
        r_rst[id] = cyc + 1;
        step();
        a_rst = 1'b0;
        b_rst = 1'b0;
    endtask

    task automatic lit(input int sel, input int arg, input int want, input int at);
        lit_sel = sel; lit_arg = arg; lit_want = want; lit_at = at;
        goto(at);
        step();
    endtask

    task automatic new_win();
        win_id++;
        step();
    endtask

    task automatic load_three();
        mem[0] = 6'o41;
        mem[1] = 6'o56;
        mem[2] = 6'o37;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        int s;
        for (int i = 0; i < 256; i++) mem[i] = 6'd0;
        repeat (3) @(posedge clk);
        #2;
        lit(11, 0, 0, cyc);
        a_rst = 1'b0;
        b_rst = 1'b0;
        step();

        // Model pins: table and octave scaling
        lit(10, 6'o71, 23889, cyc);
        lit(10, 6'o46, 113636, cyc);
        lit(10, 6'o11, 1528904, cyc);
        lit(10, 6'o76, 14204, cyc);

        // Three entries played to completion
        load_three();
        new_win();
        do_start(0, 3, 1'b1);
        s = r_s[0];
        goto(s + 32);
        lit(1, 0, 3, cyc);
        lit(6, 0, 0, cyc);
        lit(2, 0, 1, cyc);
        lit(3, 0, 30, cyc);
        lit(4, 0, 24, cyc);
        lit(7, 0, 0, cyc);
        lit(8, 0, 6'o37, cyc);
        lit(5, 0, 0, cyc);

        // Rests: note 0 and octave 0
        mem[0] = 6'o40;
        mem[1] = 6'o03;
        new_win();
        do_start(0, 2, 1'b1);
        s = r_s[0];
        goto(s + 22);
        lit(4, 0, 16, cyc);
        lit(5, 0, 0, cyc);
        lit(2, 0, 1, cyc);

        // Zero length
        new_win();
        do_start(0, 0, 1'b1);
        s = r_s[0];
        goto(s + 3);
        lit(2, 0, 1, cyc);
        lit(3, 0, 0, cyc);
        lit(1, 0, 0, cyc);

        // Stop during PLAY of entry 1, then replay from entry 0
        load_three();
        new_win();
        do_start(0, 3, 1'b1);
        s = r_s[0];
        goto(s + 14);
        do_stop(0);
        goto(s + 40);
        lit(1, 0, 2, cyc);
        lit(2, 0, 0, cyc);
        lit(8, 0, 0, cyc);
        new_win();
        do_start(0, 3, 1'b1);
        s = r_s[0];
        lit(7, 0, 0, s + 3);
        goto(s + 32);
        lit(2, 0, 1, cyc);

        // Reset while in WAIT
        new_win();
        do_start(0, 3, 1'b1);
        s = r_s[0];
        goto(s + 1);
        do_rst(0);
        lit(11, 0, 0, cyc);

        // Start while busy is ignored
        new_win();
        do_start(0, 3, 1'b1);
        s = r_s[0];
        goto(s + 5);
        do_start(0, 2, 1'b0);
        goto(s + 32);
        lit(1, 0, 3, cyc);
        lit(6, 0, 0, cyc);
        lit(2, 0, 1, cyc);
        lit(8, 0, 6'o37, cyc);

        // Audible tones on the long-duration instance: {7,1} then {7,6}
        mem[0] = 6'o71;
        mem[1] = 6'o76;
        do_start(1, 2, 1'b1);
        s = r_s[1];
        lit(9, 0, 0, s + 23890);
        lit(9, 0, 1, s + 23891);
        lit(9, 0, 0, s + 25002);
        lit(9, 0, 0, s + 25004);
        lit(9, 0, 0, s + 39207);
        lit(9, 0, 1, s + 39208);
        goto(s + 50006);

        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
